// File: rtl/approx_adder_pkg.sv
// -----------------------------------------------------------------------------
// approx_adder_pkg
// Shared types and helpers for the approximate adder pipeline.
//   mode_e   : per-transaction arithmetic mode (exact / lower-part-OR approx)
//   loa_add  : lower-part-OR adder on operands zero-extended to LOA_MAX_W bits
// Modules derive their own result width locally as SUM_W = WIDTH + 1.
// -----------------------------------------------------------------------------
package approx_adder_pkg;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    // Widest operand the shared helper handles; callers zero-extend into it.
    localparam int LOA_MAX_W = 32;

    // Lower-part-OR addition. The low l bits are a|b, the carry into the
    // exact upper part is the AND of the top approximated bit pair.
    // Operands must be zero above the caller's width, so the result is
    // exactly caller_width+1 bits wide in the low end of the return value.
    function automatic logic [LOA_MAX_W:0] loa_add(
        input logic [LOA_MAX_W-1:0] a,
        input logic [LOA_MAX_W-1:0] b,
        input int                   l
    );
        logic [LOA_MAX_W-1:0] lo_v;
        logic [LOA_MAX_W-1:0] a_hi_v;
        logic [LOA_MAX_W-1:0] b_hi_v;
        logic [LOA_MAX_W:0]   hi_v;
        logic                 c_v;
        lo_v = '0;
        c_v  = 1'b0;
        for (int i = 0; i < LOA_MAX_W; i++) begin
            if (i < l) begin
                lo_v[i] = a[i] | b[i];
            end else begin
                lo_v[i] = 1'b0;
            end
            if (i + 1 == l) begin
                c_v = a[i] & b[i];
            end else begin
                c_v = c_v;
            end
        end
        a_hi_v = a >> l;
        b_hi_v = b >> l;
        hi_v   = {1'b0, a_hi_v} + {1'b0, b_hi_v} + {{LOA_MAX_W{1'b0}}, c_v};
        return (hi_v << l) | {1'b0, lo_v};
    endfunction

endpackage

// File: rtl/approx_adder_core.sv
// -----------------------------------------------------------------------------
// approx_adder_core
// Combinational datapath between the two pipeline stages.
//   a, b     in  WIDTH    operands
//   mode     in  mode_e   exact or approximate
//   sum      out WIDTH+1  selected result
//   err_abs  out WIDTH+1  |exact - approx| in approx mode, 0 in exact mode
// -----------------------------------------------------------------------------
module approx_adder_core
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  mode_e            mode,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   err_abs
);

    localparam int SUM_W = WIDTH + 1;

    if (WIDTH > LOA_MAX_W) begin : g_width_check
        $error("approx_adder_core: WIDTH exceeds LOA_MAX_W");
    end

    logic [LOA_MAX_W-1:0] a_ext_s;
    logic [LOA_MAX_W-1:0] b_ext_s;
    logic [SUM_W-1:0]     exact_s;
    logic [SUM_W-1:0]     approx_s;

    // Both candidate sums; the approximate one is truncated back to SUM_W
    // because the helper's upper bits are always zero for zero-extended inputs.
    always_comb begin
        a_ext_s             = '0;
        b_ext_s             = '0;
        a_ext_s[WIDTH-1:0]  = a;
        b_ext_s[WIDTH-1:0]  = b;
        exact_s             = {1'b0, a} + {1'b0, b};
        approx_s            = SUM_W'(loa_add(a_ext_s, b_ext_s, APPROX_BITS));
    end

    // Result and error selection by mode.
    always_comb begin
        sum     = '0;
        err_abs = '0;
        case (mode)
            MODE_EXACT: begin
                sum     = exact_s;
                err_abs = '0;
            end
            MODE_APPROX: begin
                sum = approx_s;
                if (approx_s > exact_s) begin
                    err_abs = approx_s - exact_s;
                end else begin
                    err_abs = exact_s - approx_s;
                end
            end
            default: begin
                sum     = exact_s;
                err_abs = '0;
            end
        endcase
    end

endmodule

// File: rtl/approx_adder_pipe.sv
// -----------------------------------------------------------------------------
// approx_adder_pipe
// Two-stage valid/ready pipeline around approx_adder_core, plus an error
// monitor that tracks the largest error and counts threshold violations.
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    operand handshake (op_a, op_b, mode)
//   out_valid/out_ready  result handshake (sum, err_abs)
//   clr_stats            synchronous clear of max_err/viol_cnt/viol_flag
//   max_err              largest err_abs accepted since last clear
//   viol_cnt             saturating count of accepted results with err_abs > ET
//   viol_flag            sticky violation indicator
// -----------------------------------------------------------------------------
module approx_adder_pipe
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4,
    parameter int ET          = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   err_abs,
    input  logic             clr_stats,
    output logic [WIDTH:0]   max_err,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             viol_flag
);

    localparam int SUM_W = WIDTH + 1;
    localparam logic [SUM_W-1:0] ET_V = SUM_W'(ET);

    if (APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_approx_check
        $error("approx_adder_pipe: APPROX_BITS must be within 0..WIDTH");
    end
    if (ET < 0 || longint'(ET) >= (longint'(1) << (WIDTH + 1))) begin : g_et_check
        $error("approx_adder_pipe: ET must be below 2^(WIDTH+1)");
    end

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    mode_e            s1_mode_r;
    logic             s2_valid_r;
    logic [SUM_W-1:0] s2_sum_r;
    logic [SUM_W-1:0] s2_err_r;
    logic [SUM_W-1:0] max_err_r;
    logic [CNT_W-1:0] viol_cnt_r;
    logic             viol_flag_r;

    logic             s2_adv_s;
    logic             s1_adv_s;
    logic             in_ready_s;
    logic             out_hs_s;
    logic [SUM_W-1:0] core_sum_s;
    logic [SUM_W-1:0] core_err_s;

    // S2 frees up when empty or drained this cycle; S1 moves only into a free S2.
    assign s2_adv_s   = ~s2_valid_r | out_ready;
    assign s1_adv_s   = s1_valid_r & s2_adv_s;
    assign in_ready_s = ~s1_valid_r | s2_adv_s;
    assign out_hs_s   = s2_valid_r & out_ready;

    approx_adder_core #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_core (
        .a       (s1_a_r),
        .b       (s1_b_r),
        .mode    (s1_mode_r),
        .sum     (core_sum_s),
        .err_abs (core_err_s)
    );

    // Stage 1: operand capture on the input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_mode_r  <= MODE_EXACT;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r    <= op_a;
                s1_b_r    <= op_b;
                s1_mode_r <= mode_e'(mode);
            end
        end
    end

    // Stage 2: result capture; data holds while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_sum_r   <= '0;
            s2_err_r   <= '0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_adv_s) begin
                s2_sum_r <= core_sum_s;
                s2_err_r <= core_err_s;
            end
        end
    end

    // Error statistics, updated on the output handshake; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_err_r   <= '0;
            viol_cnt_r  <= '0;
            viol_flag_r <= 1'b0;
        end else if (clr_stats) begin
            max_err_r   <= '0;
            viol_cnt_r  <= '0;
            viol_flag_r <= 1'b0;
        end else if (out_hs_s) begin
            if (s2_err_r > max_err_r) begin
                max_err_r <= s2_err_r;
            end
            if (s2_err_r > ET_V) begin
                viol_flag_r <= 1'b1;
                if (viol_cnt_r != {CNT_W{1'b1}}) begin
                    viol_cnt_r <= viol_cnt_r + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_r;
    assign sum       = s2_sum_r;
    assign err_abs   = s2_err_r;
    assign max_err   = max_err_r;
    assign viol_cnt  = viol_cnt_r;
    assign viol_flag = viol_flag_r;

endmodule
